// File: rtl/gpio_loader_pkg.sv
// Shared types and defaults for the GPIO serial configuration loader.
package gpio_loader_pkg;

    localparam int unsigned DEF_NUM_IO = 38;
    localparam int unsigned DEF_CFG_W  = 13;
    localparam int unsigned DIV_W      = 8;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        DONE
    } loader_state_e;

    // Bits pushed into each of the two chains (each chain serves half the pads).
    function automatic int unsigned chain_bits(input int unsigned num_io, input int unsigned cfg_w);
        return (num_io / 2) * cfg_w;
    endfunction

endpackage

// File: rtl/gpio_serial_loader_if.sv
// Serial control-chain bundle between the loader and the GPIO pad chains.
interface gpio_serial_loader_if;

    logic serial_clock;
    logic serial_load;
    logic serial_resetn;
    logic serial_data_1;
    logic serial_data_2;

    modport master (
        output serial_clock,
        output serial_load,
        output serial_resetn,
        output serial_data_1,
        output serial_data_2
    );

    modport slave (
        input serial_clock,
        input serial_load,
        input serial_resetn,
        input serial_data_1,
        input serial_data_2
    );

endinterface

// File: rtl/gpio_loader_clkdiv.sv
// Phase divider: phase_tick marks the last cycle of each DIV-cycle phase.
module gpio_loader_clkdiv
    import gpio_loader_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic restart,
    input  logic run,
    output logic phase_tick
);

    localparam logic [DIV_W-1:0] RELOAD    = DIV_W'(DIV - 1);
    localparam logic             ONE_CYCLE = 1'(DIV == 1);

    logic [DIV_W-1:0] cnt;

    // Reload on start and on every phase change so each phase is exactly DIV cycles.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt        <= '0;
            phase_tick <= 1'b0;
        end else if (restart || (run && phase_tick)) begin
            cnt        <= RELOAD;
            phase_tick <= ONE_CYCLE;
        end else if (run) begin
            cnt        <= cnt - DIV_W'(1);
            phase_tick <= (cnt == DIV_W'(1));
        end else begin
            phase_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/gpio_serial_loader.sv
// Shifts per-pad GPIO configuration into two serial control chains, then strobes load.
// Optional bit-bang override of the chain outputs: define GPIO_LOADER_BITBANG_EN.
module gpio_serial_loader
    import gpio_loader_pkg::*;
#(
    parameter int unsigned NUM_IO  = DEF_NUM_IO,
    parameter int unsigned CFG_W   = DEF_CFG_W,
    parameter int unsigned CLK_DIV = 1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      start_i,
    input  logic [NUM_IO*CFG_W-1:0]   cfg_i,
`ifdef GPIO_LOADER_BITBANG_EN
    input  logic                      bb_en_i,
    input  logic                      bb_clock_i,
    input  logic                      bb_data_1_i,
    input  logic                      bb_data_2_i,
    input  logic                      bb_load_i,
`endif
    gpio_serial_loader_if.master      chain,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int unsigned HALF  = NUM_IO / 2;
    localparam int unsigned BITS  = chain_bits(NUM_IO, CFG_W);
    localparam int unsigned CNT_W = $clog2(BITS + 1);

    loader_state_e    state;
    logic [CNT_W-1:0] bit_cnt;
    logic [BITS-1:0]  sh1;
    logic [BITS-1:0]  sh2;
    logic [BITS-1:0]  cfg2;
    logic             sclk_q;
    logic             load_q;
    logic             resetn_q;
    logic             phase_tick;
    logic             start_ok;

    // Chain 2 starts at pad HALF: reverse pad order so both chains shift MSB-first from the top.
    always_comb begin
        cfg2 = '0;
        for (int unsigned j = 0; j < HALF; j++) begin
            cfg2[(HALF-1-j)*CFG_W +: CFG_W] = cfg_i[(HALF+j)*CFG_W +: CFG_W];
        end
    end

`ifdef GPIO_LOADER_BITBANG_EN
    logic bb_sel;

    assign bb_sel   = (state == IDLE) && bb_en_i;
    assign start_ok = (state == IDLE) && start_i && !bb_en_i;

    // Software drives the chains directly while the loader is idle.
    assign chain.serial_clock  = bb_sel ? bb_clock_i  : sclk_q;
    assign chain.serial_load   = bb_sel ? bb_load_i   : load_q;
    assign chain.serial_data_1 = bb_sel ? bb_data_1_i : sh1[BITS-1];
    assign chain.serial_data_2 = bb_sel ? bb_data_2_i : sh2[BITS-1];
`else
    assign start_ok = (state == IDLE) && start_i;

    assign chain.serial_clock  = sclk_q;
    assign chain.serial_load   = load_q;
    assign chain.serial_data_1 = sh1[BITS-1];
    assign chain.serial_data_2 = sh2[BITS-1];
`endif

    assign chain.serial_resetn = resetn_q;

    gpio_loader_clkdiv #(
        .DIV (CLK_DIV)
    ) u_clkdiv (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .restart    (start_ok),
        .run        (busy_o),
        .phase_tick (phase_tick)
    );

    // Transfer sequencer; shift registers double as the configuration snapshot.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            sh1      <= '0;
            sh2      <= '0;
            sclk_q   <= 1'b0;
            load_q   <= 1'b0;
            resetn_q <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            resetn_q <= 1'b1;
            done_o   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        state   <= SHIFT_LO;
                        busy_o  <= 1'b1;
                        sclk_q  <= 1'b0;
                        sh1     <= cfg_i[BITS-1:0];
                        sh2     <= cfg2;
                        bit_cnt <= CNT_W'(BITS - 1);
                    end
                end
                SHIFT_LO: begin
                    if (phase_tick) begin
                        state  <= SHIFT_HI;
                        sclk_q <= 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (phase_tick) begin
                        sclk_q <= 1'b0;
                        if (bit_cnt == '0) begin
                            state  <= LOAD;
                            load_q <= 1'b1;
                        end else begin
                            state   <= SHIFT_LO;
                            bit_cnt <= bit_cnt - CNT_W'(1);
                            sh1     <= {sh1[BITS-2:0], 1'b0};
                            sh2     <= {sh2[BITS-2:0], 1'b0};
                        end
                    end
                end
                LOAD: begin
                    if (phase_tick) begin
                        state  <= DONE;
                        load_q <= 1'b0;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
